fifo_uart_drain: RTL and testbench

- Read-side consumer for the team's byte FIFO: pops bytes from the FIFO read port and sends each one out as an asynchronous serial frame (UART 8N1, optional even parity).
- Sits between the FIFO read port and an output pin, so buffered data can leave the chip without a second external handshake.
- One clock domain. No flow control on the serial side.

---
 rtl/fifo_uart_drain.sv | 95 +++++++++
 tb/tb_fifo_uart_drain.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_drain.sv
// Drains a byte FIFO onto a UART 8N1 line (optional even parity).
// Pops one byte per frame and can chain frames back-to-back while enabled.
module fifo_uart_drain #(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_EN    = 1'b0,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [7:0]       fifo_rd_data,
   output logic             tx,
   output logic             busy,
   output logic [CNT_W-1:0] frames_sent
);

   typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, PARITY, STOP} state_t;

   localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);

   state_t      state, state_nxt;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx, bit_nxt;
   logic [7:0]  data;
   logic        par;
   logic        tx_nxt, rd_en_nxt;
   logic        last_tick, timed;

   assign last_tick = (baud_cnt == LAST_TICK);
   assign timed     = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         baud_cnt    <= '0;
         bit_idx     <= '0;
         data        <= '0;
         par         <= 1'b0;
         tx          <= 1'b1;
         fifo_rd_en  <= 1'b0;
         frames_sent <= '0;
      end else begin
         state      <= state_nxt;
         bit_idx    <= bit_nxt;
         tx         <= tx_nxt;
         fifo_rd_en <= rd_en_nxt;
         // The counter restarts at every bit or state boundary
         baud_cnt   <= (!timed || last_tick) ? 16'd0 : baud_cnt + 16'd1;
         if (state == LATCH) begin
            data <= fifo_rd_data;
            par  <= ^fifo_rd_data;
         end
         if (state == STOP && last_tick)
            frames_sent <= frames_sent + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      bit_nxt   = bit_idx;
      case (state)
         IDLE:   if (enable && !fifo_empty) state_nxt = POP;
         POP:    state_nxt = LATCH;
         LATCH:  state_nxt = START;
         START:  if (last_tick) begin
                    state_nxt = DATA;
                    bit_nxt   = 3'd0;
                 end
         DATA:   if (last_tick) begin
                    if (bit_idx == 3'd7) state_nxt = PARITY_EN ? PARITY : STOP;
                    else                 bit_nxt   = bit_idx + 3'd1;
                 end
         PARITY: if (last_tick) state_nxt = STOP;
         STOP:   if (last_tick) state_nxt = (enable && !fifo_empty) ? POP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are computed from the next state so tx and the pop strobe are registered
   always_comb begin
      rd_en_nxt = (state_nxt == POP);
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = data[bit_nxt];
         PARITY:  tx_nxt = par;
         default: tx_nxt = 1'b1;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: two instances (no parity / 4-bit counter, parity / 16-bit
// counter) fed by behavioural FIFOs, frames compared against a per-cycle waveform model.
module tb_fifo_uart_drain;

   localparam int CPB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        en_a, en_b;
   logic        rd_en_a, rd_en_b, tx_a, tx_b, busy_a, busy_b;
   logic        empty_a, empty_b;
   logic [7:0]  rd_data_a = 8'h00, rd_data_b = 8'h00;
   logic [3:0]  fs_a;
   logic [15:0] fs_b;

   logic [7:0]  mem [2][64];
   int          wr_ptr [2] = '{0, 0};
   int          rd_ptr [2] = '{0, 0};
   int          pops   [2] = '{0, 0};
   int          exp_fs [2] = '{0, 0};
   int          n_chk = 0, n_fail = 0;

   assign empty_a = (wr_ptr[0] == rd_ptr[0]);
   assign empty_b = (wr_ptr[1] == rd_ptr[1]);

   fifo_uart_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .enable(en_a), .fifo_empty(empty_a), .fifo_rd_en(rd_en_a),
      .fifo_rd_data(rd_data_a), .tx(tx_a), .busy(busy_a), .frames_sent(fs_a));

   fifo_uart_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .enable(en_b), .fifo_empty(empty_b), .fifo_rd_en(rd_en_b),
      .fifo_rd_data(rd_data_b), .tx(tx_b), .busy(busy_b), .frames_sent(fs_b));

   // FIFO read side with 1-cycle latency; popping an empty FIFO is an error
   always @(posedge clk) begin
      if (rd_en_a) begin
         n_chk++;
         if (empty_a) begin n_fail++; $display("FAIL rd_en_while_empty_a: got rd_en=1 required 0"); end
         rd_data_a <= mem[0][rd_ptr[0] % 64];
         rd_ptr[0] <= rd_ptr[0] + 1;
         pops[0]++;
      end
      if (rd_en_b) begin
         n_chk++;
         if (empty_b) begin n_fail++; $display("FAIL rd_en_while_empty_b: got rd_en=1 required 0"); end
         rd_data_b <= mem[1][rd_ptr[1] % 64];
         rd_ptr[1] <= rd_ptr[1] + 1;
         pops[1]++;
      end
   end

   function automatic logic g_tx(input int i);    return (i == 0) ? tx_a    : tx_b;    endfunction
   function automatic logic g_busy(input int i);  return (i == 0) ? busy_a  : busy_b;  endfunction
   function automatic logic g_rd(input int i);    return (i == 0) ? rd_en_a : rd_en_b; endfunction
   function automatic int   g_fs(input int i);    return (i == 0) ? int'(fs_a) : int'(fs_b); endfunction
   function automatic int   fs_mod(input int i, input int v); return (i == 0) ? v % 16 : v % 65536; endfunction
   function automatic int   par_en(input int i);  return (i == 0) ? 0 : 1; endfunction
   function automatic int   frame_len(input int i); return 2 + (10 + par_en(i)) * CPB; endfunction

   // Expected {rd_en, busy, tx} at cycle k of a frame, k=0 being the pop cycle
   function automatic logic [2:0] exp_sig(input int pe, input logic [7:0] b, input int k);
      int   bp;
      logic t;
      if (k == 0) return 3'b111;
      if (k == 1) return 3'b011;
      bp = (k - 2) / CPB;
      if (bp == 0)                  t = 1'b0;
      else if (bp <= 8)             t = b[bp-1];
      else if (pe == 1 && bp == 9)  t = ^b;
      else                          t = 1'b1;
      return {1'b0, 1'b1, t};
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, got, exp);
      end
   endtask

   task automatic set_en(input int i, input logic v);
      if (i == 0) en_a = v; else en_b = v;
   endtask

   task automatic push(input int i, input logic [7:0] b);
      mem[i][wr_ptr[i] % 64] = b;
      wr_ptr[i]++;
   endtask

   // Waits for the pop strobe, then checks n contiguous frames cycle by cycle
   task automatic run_frames(input int i, input int n, input logic [3:0][7:0] b, input int drop_at);
      int         found = 0, bad, fk;
      logic [2:0] act, exp, fa, fe;
      for (int t = 0; t < 20 && found == 0; t++) begin
         @(negedge clk);
         if (g_rd(i)) found = 1;
      end
      check($sformatf("dut%0d_pop_seen", i), found, 1);
      if (found == 0) return;
      for (int j = 0; j < n; j++) begin
         bad = 0; fk = -1; fa = '0; fe = '0;
         for (int k = 0; k < frame_len(i); k++) begin
            act = {g_rd(i), g_busy(i), g_tx(i)};
            exp = exp_sig(par_en(i), b[j], k);
            if (act != exp) begin
               if (bad == 0) begin fk = k; fa = act; fe = exp; end
               bad++;
            end
            if (j == 0 && k == drop_at) set_en(i, 1'b0);
            @(negedge clk);
         end
         check($sformatf("dut%0d_frame%0d_byte%02h_bad_cycles(first k=%0d rd/busy/tx got %b want %b)",
                         i, j, b[j], fk, fa, fe), bad, 0);
         exp_fs[i]++;
      end
      check($sformatf("dut%0d_idle_busy", i), int'(g_busy(i)), 0);
      check($sformatf("dut%0d_idle_tx", i), int'(g_tx(i)), 1);
      check($sformatf("dut%0d_frames_sent", i), g_fs(i), fs_mod(i, exp_fs[i]));
   endtask

   typedef struct {
      int              dut;
      int              n;
      logic [3:0][7:0] b;
   } vec_t;

   vec_t tbl [5];

   initial begin
      int p0, found;
      logic [3:0][7:0] bb;

      tbl[0] = '{dut: 1, n: 1, b: {8'h00, 8'h00, 8'h00, 8'h07}};
      tbl[1] = '{dut: 0, n: 3, b: {8'h00, 8'h3C, 8'hFF, 8'h00}};
      tbl[2] = '{dut: 1, n: 3, b: 32'($urandom)};
      tbl[3] = '{dut: 0, n: 4, b: 32'($urandom)};
      tbl[4] = '{dut: 1, n: 2, b: 32'($urandom)};

      // Reset held with a non-empty FIFO and enable high
      rst = 1'b1; en_a = 1'b1; en_b = 1'b0;
      push(0, 8'hA5);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_tx", int'(tx_a), 1);
         check("rst_rd_en", int'(rd_en_a), 0);
         check("rst_busy", int'(busy_a), 0);
         check("rst_frames_sent", int'(fs_a), 0);
      end
      rst = 1'b0;
      run_frames(0, 1, {8'h00, 8'h00, 8'h00, 8'hA5}, -1);
      en_a = 1'b0;
      check("a5_pop_count", pops[0], 1);

      for (int v = 0; v < 5; v++) begin
         p0 = pops[tbl[v].dut];
         for (int j = 0; j < tbl[v].n; j++) push(tbl[v].dut, tbl[v].b[j]);
         set_en(tbl[v].dut, 1'b1);
         run_frames(tbl[v].dut, tbl[v].n, tbl[v].b, -1);
         set_en(tbl[v].dut, 1'b0);
         check($sformatf("vec%0d_pop_count", v), pops[tbl[v].dut] - p0, tbl[v].n);
      end

      // Enable dropped during data bit 3 with two bytes queued
      bb = 32'($urandom);
      p0 = pops[0];
      push(0, bb[0]); push(0, bb[1]);
      en_a = 1'b1;
      run_frames(0, 1, bb, 2 + 4 * CPB + 1);
      repeat (30) @(negedge clk);
      check("drop_pop_count", pops[0] - p0, 1);
      check("drop_busy", int'(busy_a), 0);

      // Reset during DATA: the popped byte is lost, next queued byte goes out cleanly
      en_a = 1'b1;
      found = 0;
      for (int t = 0; t < 20 && found == 0; t++) begin
         @(negedge clk);
         if (rd_en_a) found = 1;
      end
      check("rstmid_pop_seen", found, 1);
      repeat (2 + 2 * CPB) @(negedge clk);
      rst = 1'b1; en_a = 1'b0;
      @(negedge clk);
      check("rstmid_tx", int'(tx_a), 1);
      check("rstmid_busy", int'(busy_a), 0);
      check("rstmid_rd_en", int'(rd_en_a), 0);
      check("rstmid_frames_sent", int'(fs_a), 0);
      exp_fs[0] = 0; exp_fs[1] = 0;
      rst = 1'b0;
      @(negedge clk);
      bb = 32'($urandom);
      push(0, bb[0]);
      en_a = 1'b1;
      run_frames(0, 1, bb, -1);
      en_a = 1'b0;

      // 16 more random frames on the 4-bit counter: 17 total wraps to 1
      for (int r = 0; r < 4; r++) begin
         bb = 32'($urandom);
         for (int j = 0; j < 4; j++) push(0, bb[j]);
         en_a = 1'b1;
         run_frames(0, 4, bb, -1);
         en_a = 1'b0;
      end
      check("wrap_frames_sent", int'(fs_a), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
